// File: rtl/port_alloc_scheduler_pkg.sv
// Shared constants, FSM state type and helpers for the bufferless port-allocation scheduler.
package port_alloc_scheduler_pkg;

  localparam int NUM_PORT       = 5;
  localparam int PC_INDEX_WIDTH = 3;
  localparam int AGE_WIDTH      = 8;

  localparam int NUM_OUT    = NUM_PORT - 1;
  localparam int NUM_FLIT   = 4;
  localparam int FLIT_IDX_W = 2;
  localparam int K_W        = FLIT_IDX_W + 1;

  localparam logic [PC_INDEX_WIDTH-1:0] PC_ONE   = PC_INDEX_WIDTH'(1);
  localparam logic [PC_INDEX_WIDTH-1:0] MC_LIMIT = PC_INDEX_WIDTH'(NUM_PORT - 1);

  typedef enum logic [1:0] {
    PORT_N = 2'd0,
    PORT_E = 2'd1,
    PORT_S = 2'd2,
    PORT_W = 2'd3
  } port_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SORT  = 2'd1,
    ALLOC = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic [K_W-1:0] popcount_flits(input logic [NUM_FLIT-1:0] v);
    logic [K_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_FLIT; i++) begin
      c = c + K_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/port_alloc_step.sv
// One allocation step for a single flit: productive grants first, then a single deflection.
module port_alloc_step
  import port_alloc_scheduler_pkg::*;
(
  input  logic [NUM_OUT-1:0]        ppv,
  input  logic                      mc,
  input  logic [NUM_OUT-1:0]        avail,
  input  logic [PC_INDEX_WIDTH-1:0] n,
  output logic [NUM_OUT-1:0]        grant,
  output logic [NUM_OUT-1:0]        avail_next,
  output logic [PC_INDEX_WIDTH-1:0] n_next
);

  logic deflect_done;

  always_comb begin
    grant        = '0;
    avail_next   = avail;
    n_next       = n;
    deflect_done = 1'b0;

    // Each grant bumps the counter at once, so later ports of a multicast see the updated count.
    for (int i = 0; i < NUM_OUT; i++) begin
      if (ppv[i] && avail_next[i] && (!mc || (n_next <= MC_LIMIT))) begin
        grant[i]      = 1'b1;
        avail_next[i] = 1'b0;
        n_next        = n_next + PC_ONE;
      end
    end

    if ((ppv != '0) && (grant == '0)) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (!deflect_done && avail_next[i]) begin
          grant[i]      = 1'b1;
          avail_next[i] = 1'b0;
          n_next        = n_next + PC_ONE;
          deflect_done  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/port_alloc_scheduler.sv
// Batch scheduler: captures up to four flits, ranks them oldest-first and allocates one per cycle.
module port_alloc_scheduler
  import port_alloc_scheduler_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic                          ready,
  input  logic [NUM_FLIT-1:0]           flit_valid,
  input  logic [NUM_FLIT*NUM_OUT-1:0]   flit_ppv,
  input  logic [NUM_FLIT*AGE_WIDTH-1:0] flit_age,
  input  logic [NUM_FLIT-1:0]           flit_mc,
  input  logic [NUM_OUT-1:0]            avail_init,
  output logic                          alloc_valid,
  output logic [NUM_FLIT*NUM_OUT-1:0]   alloc_vec,
  output logic [PC_INDEX_WIDTH-1:0]     num_flit,
  output logic [NUM_FLIT-1:0]           unalloc
);

  state_e state_q, state_d;

  logic [NUM_FLIT-1:0]           valid_q, valid_d;
  logic [NUM_FLIT*NUM_OUT-1:0]   ppv_q, ppv_d;
  logic [NUM_FLIT*AGE_WIDTH-1:0] age_q, age_d;
  logic [NUM_FLIT-1:0]           mc_q, mc_d;
  logic [NUM_OUT-1:0]            avail_init_q, avail_init_d;

  logic [NUM_FLIT-1:0][FLIT_IDX_W-1:0] order_q, order_d, order_sorted;
  logic [K_W-1:0]                      k_q, k_d;
  logic [FLIT_IDX_W-1:0]               idx_q, idx_d;
  logic [NUM_OUT-1:0]                  avail_q, avail_d;
  logic [PC_INDEX_WIDTH-1:0]           n_q, n_d;
  logic [NUM_FLIT*NUM_OUT-1:0]         work_vec_q, work_vec_d;
  logic [NUM_FLIT-1:0]                 work_un_q, work_un_d;

  logic                          alloc_valid_q, alloc_valid_d;
  logic [NUM_FLIT*NUM_OUT-1:0]   alloc_vec_q, alloc_vec_d;
  logic [PC_INDEX_WIDTH-1:0]     num_flit_q, num_flit_d;
  logic [NUM_FLIT-1:0]           unalloc_q, unalloc_d;

  logic [FLIT_IDX_W-1:0]         cur;
  logic [NUM_OUT-1:0]            cur_ppv;
  logic                          cur_mc;
  logic [NUM_OUT-1:0]            step_grant;
  logic [NUM_OUT-1:0]            step_avail;
  logic [PC_INDEX_WIDTH-1:0]     step_n;

  assign cur     = order_q[idx_q];
  assign cur_ppv = ppv_q[cur*NUM_OUT +: NUM_OUT];
  assign cur_mc  = mc_q[cur];

  port_alloc_step u_step (
    .ppv        (cur_ppv),
    .mc         (cur_mc),
    .avail      (avail_q),
    .n          (n_q),
    .grant      (step_grant),
    .avail_next (step_avail),
    .n_next     (step_n)
  );

  // Rank = number of valid flits that beat this one (older, or same age with lower index).
  always_comb begin : rank_c
    logic [K_W-1:0]       rank;
    logic [AGE_WIDTH-1:0] age_i;
    logic [AGE_WIDTH-1:0] age_j;
    order_sorted = '0;
    for (int i = 0; i < NUM_FLIT; i++) begin
      age_i = age_q[i*AGE_WIDTH +: AGE_WIDTH];
      rank  = '0;
      for (int j = 0; j < NUM_FLIT; j++) begin
        age_j = age_q[j*AGE_WIDTH +: AGE_WIDTH];
        if (valid_q[j] && ((age_j > age_i) || ((age_j == age_i) && (j < i)))) begin
          rank = rank + K_W'(1);
        end
      end
      if (valid_q[i]) begin
        order_sorted[rank[FLIT_IDX_W-1:0]] = FLIT_IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    ppv_d        = ppv_q;
    age_d        = age_q;
    mc_d         = mc_q;
    avail_init_d = avail_init_q;
    order_d      = order_q;
    k_d          = k_q;
    idx_d        = idx_q;
    avail_d      = avail_q;
    n_d          = n_q;
    work_vec_d   = work_vec_q;
    work_un_d    = work_un_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          valid_d      = flit_valid;
          ppv_d        = flit_ppv;
          age_d        = flit_age;
          mc_d         = flit_mc;
          avail_init_d = avail_init;
          state_d      = SORT;
        end
      end
      SORT: begin
        order_d    = order_sorted;
        k_d        = popcount_flits(valid_q);
        idx_d      = '0;
        n_d        = '0;
        avail_d    = avail_init_q;
        work_vec_d = '0;
        work_un_d  = '0;
        state_d    = (k_d == '0) ? DONE : ALLOC;
      end
      ALLOC: begin
        avail_d                               = step_avail;
        n_d                                   = step_n;
        work_vec_d[cur*NUM_OUT +: NUM_OUT]    = step_grant;
        work_un_d[cur]                        = (cur_ppv != '0) && (step_grant == '0);
        idx_d                                 = idx_q + FLIT_IDX_W'(1);
        if (({1'b0, idx_q} + K_W'(1)) == k_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Results are loaded on the edge entering DONE so they are stable while alloc_valid is high.
  always_comb begin
    alloc_valid_d = (state_d == DONE);
    alloc_vec_d   = alloc_vec_q;
    num_flit_d    = num_flit_q;
    unalloc_d     = unalloc_q;
    if (state_d == DONE) begin
      alloc_vec_d = work_vec_d;
      num_flit_d  = n_d;
      unalloc_d   = work_un_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      alloc_valid_q <= 1'b0;
      alloc_vec_q   <= '0;
      num_flit_q    <= '0;
      unalloc_q     <= '0;
    end else begin
      state_q       <= state_d;
      alloc_valid_q <= alloc_valid_d;
      alloc_vec_q   <= alloc_vec_d;
      num_flit_q    <= num_flit_d;
      unalloc_q     <= unalloc_d;
    end
  end

  // Working datapath registers are always rewritten before use, so they carry no reset.
  always_ff @(posedge clk) begin
    valid_q      <= valid_d;
    ppv_q        <= ppv_d;
    age_q        <= age_d;
    mc_q         <= mc_d;
    avail_init_q <= avail_init_d;
    order_q      <= order_d;
    k_q          <= k_d;
    idx_q        <= idx_d;
    avail_q      <= avail_d;
    n_q          <= n_d;
    work_vec_q   <= work_vec_d;
    work_un_q    <= work_un_d;
  end

  assign ready       = (state_q == IDLE) && !reset;
  assign alloc_valid = alloc_valid_q;
  assign alloc_vec   = alloc_vec_q;
  assign num_flit    = num_flit_q;
  assign unalloc     = unalloc_q;

endmodule

// File: tb/tb_port_alloc_scheduler.sv
// Scoreboard bench for port_alloc_scheduler: directed scenarios plus randomized batches.
module tb_port_alloc_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        ready;
  logic [3:0]  flit_valid = '0;
  logic [15:0] flit_ppv = '0;
  logic [31:0] flit_age = '0;
  logic [3:0]  flit_mc = '0;
  logic [3:0]  avail_init = '0;
  logic        alloc_valid;
  logic [15:0] alloc_vec;
  logic [2:0]  num_flit;
  logic [3:0]  unalloc;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] vec;
    logic [2:0]  num;
    logic [3:0]  un;
    int          lat;
    int          c0;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  port_alloc_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ready       (ready),
    .flit_valid  (flit_valid),
    .flit_ppv    (flit_ppv),
    .flit_age    (flit_age),
    .flit_mc     (flit_mc),
    .avail_init  (avail_init),
    .alloc_valid (alloc_valid),
    .alloc_vec   (alloc_vec),
    .num_flit    (num_flit),
    .unalloc     (unalloc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every alloc_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (alloc_valid !== 1'b0) begin
      if (sb.size() == 0) begin
        chk("unexpected_alloc_valid", {31'd0, alloc_valid}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("alloc_vec", alloc_vec, mon_e.vec);
        chk("num_flit", num_flit, mon_e.num);
        chk("unalloc", unalloc, mon_e.un);
        chk("latency", cyc - mon_e.c0 + 1, mon_e.lat);
      end
    end
  end

  function automatic void model(input logic [3:0] v, input logic [15:0] p, input logic [31:0] a,
                                input logic [3:0] m, input logic [3:0] av,
                                output logic [15:0] ev, output logic [2:0] en, output logic [3:0] eu);
    logic [3:0] taken, pool, g, pp;
    int n, best;
    ev = '0; eu = '0; n = 0; pool = av; taken = '0;
    for (int r = 0; r < 4; r++) begin
      best = -1;
      for (int i = 0; i < 4; i++) begin
        if (v[i] && !taken[i]) begin
          if (best < 0) best = i;
          else if (a[i*8 +: 8] > a[best*8 +: 8]) best = i;
        end
      end
      if (best >= 0) begin
        taken[best] = 1'b1;
        pp = p[best*4 +: 4];
        g = '0;
        for (int q = 0; q < 4; q++) begin
          if (pp[q] && pool[q] && (!m[best] || n <= 4)) begin
            g[q] = 1'b1; pool[q] = 1'b0; n++;
          end
        end
        if (pp != 0 && g == 0) begin
          for (int q = 0; q < 4; q++) begin
            if (g == 0 && pool[q]) begin
              g[q] = 1'b1; pool[q] = 1'b0; n++;
            end
          end
        end
        ev[best*4 +: 4] = g;
        if (pp != 0 && g == 0) eu[best] = 1'b1;
      end
    end
    en = n[2:0];
  endfunction

  task automatic issue(input logic [3:0] v, input logic [15:0] p, input logic [31:0] a,
                       input logic [3:0] m, input logic [3:0] av, input bit expect_out,
                       input logic [15:0] ev, input logic [2:0] en, input logic [3:0] eu);
    exp_t e;
    int w;
    w = 0;
    while (ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_start", {31'd0, ready}, 32'd1);
    flit_valid = v; flit_ppv = p; flit_age = a; flit_mc = m; avail_init = av;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (expect_out) begin
      e.vec = ev; e.num = en; e.un = eu;
      e.lat = $countones(v) + 2;
      e.c0 = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic drain(input logic [15:0] ev);
    int w;
    @(negedge clk);
    chk("ready_busy", {31'd0, ready}, 32'd0);
    w = 0;
    while (sb.size() != 0 && w < 20) begin
      @(posedge clk);
      #2;
      w++;
    end
    chk("result_timeout", sb.size(), 32'd0);
    chk("pulse_one_cycle", {31'd0, alloc_valid}, 32'd0);
    chk("hold_vec", alloc_vec, ev);
  endtask

  task automatic send(input logic [3:0] v, input logic [15:0] p, input logic [31:0] a,
                      input logic [3:0] m, input logic [3:0] av,
                      input logic [15:0] ev, input logic [2:0] en, input logic [3:0] eu);
    issue(v, p, a, m, av, 1'b1, ev, en, eu);
    drain(ev);
  endtask

  initial begin
    logic [3:0]  rv, rm, rav, eu;
    logic [15:0] rp, ev;
    logic [31:0] ra;
    logic [2:0]  en;

    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_alloc_valid", {31'd0, alloc_valid}, 32'd0);
      chk("rst_alloc_vec", alloc_vec, 32'd0);
      chk("rst_num_flit", num_flit, 32'd0);
      chk("rst_unalloc", unalloc, 32'd0);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_reset", {31'd0, ready}, 32'd1);

    // Single unicast; invalid flit1 carries a ppv that must be ignored.
    send(4'b0001, 16'h00F2, 32'h0, 4'h0, 4'hF, 16'h0002, 3'd1, 4'h0);
    // Older flit1 wins N, flit0 deflected to E.
    send(4'b0011, 16'h0011, 32'h00000905, 4'h0, 4'hF, 16'h0012, 3'd2, 4'h0);
    // Equal ages: lower index first.
    send(4'b0011, 16'h0011, 32'h00000505, 4'h0, 4'hF, 16'h0021, 3'd2, 4'h0);
    // Multicast after an older unicast.
    send(4'b0101, 16'h0F04, 32'h00030007, 4'b0100, 4'hF, 16'h0B04, 3'd4, 4'h0);
    // Port exhaustion.
    send(4'b1111, 16'h4444, 32'h01020304, 4'h0, 4'b0011, 16'h0021, 3'd2, 4'b1100);
    // Empty batch.
    send(4'b0000, 16'hFFFF, 32'hFFFFFFFF, 4'hF, 4'hF, 16'h0000, 3'd0, 4'h0);

    // start during ALLOC is ignored: exactly one result.
    issue(4'b1111, 16'h1111, 32'h04030201, 4'h0, 4'hF, 1'b1, 16'h1248, 3'd4, 4'h0);
    @(negedge clk);
    @(negedge clk);
    flit_valid = 4'b0001; flit_ppv = 16'h0008; avail_init = 4'hF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain(16'h1248);
    repeat (8) @(negedge clk);
    chk("ready_after_ignored_start", {31'd0, ready}, 32'd1);

    // Reset during ALLOC abandons the batch and clears outputs.
    issue(4'b1111, 16'h1111, 32'h04030201, 4'h0, 4'hF, 1'b0, 16'h0, 3'd0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("midrst_ready", {31'd0, ready}, 32'd0);
      chk("midrst_alloc_vec", alloc_vec, 32'd0);
    end
    reset = 1'b0;
    #1;
    chk("midrst_ready_after", {31'd0, ready}, 32'd1);
    chk("midrst_num_flit", num_flit, 32'd0);
    chk("midrst_unalloc", unalloc, 32'd0);
    repeat (8) @(negedge clk);
    chk("midrst_no_pulse_ready", {31'd0, ready}, 32'd1);
    send(4'b0001, 16'h0004, 32'h0, 4'h0, 4'hF, 16'h0004, 3'd1, 4'h0);

    for (int t = 0; t < 24; t++) begin
      rv = 4'($urandom_range(0, 15));
      rm = 4'($urandom_range(0, 15));
      rav = 4'($urandom_range(0, 15));
      rp = '0;
      ra = '0;
      for (int i = 0; i < 4; i++) begin
        ra[i*8 +: 8] = 8'($urandom_range(0, 3));
        if (rm[i]) rp[i*4 +: 4] = 4'($urandom_range(0, 15));
        else if ($urandom_range(0, 4) == 4) rp[i*4 +: 4] = 4'h0;
        else rp[i*4 +: 4] = 4'(1 << $urandom_range(0, 3));
      end
      model(rv, rp, ra, rm, rav, ev, en, eu);
      send(rv, rp, ra, rm, rav, ev, en, eu);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
